// File: rtl/vga_sprite_overlay.sv
// vga_sprite_overlay: multi-slot double-buffered character sprite engine composited over a background.
// Slot word layout: {en[39], fg[38:27], ys[26:18], xs[17:8], char[7:0]}.
module vga_sprite_overlay #(
    parameter int          NUM_SLOTS = 4,
    parameter int          SPRITE_W  = 50,
    parameter int          SPRITE_H  = 50,
    parameter int          ADDR_W    = 18,
    parameter logic [31:0] BASE_ADDR = 32'h2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic              active,
    input  logic              screen_end,
    input  logic [31:0]       proc_addr,
    input  logic [31:0]       proc_data,
    input  logic              proc_we,
    output logic [ADDR_W-1:0] sprite_addr,
    input  logic              sprite_bit,
    output logic [11:0]       rgb,
    output logic              frame_irq
);
    localparam logic [39:0] SLOT_RST = 40'h20;

    logic [39:0]       pend_q [NUM_SLOTS];
    logic [39:0]       pend_d [NUM_SLOTS];
    logic [39:0]       live_q [NUM_SLOTS];
    logic [11:0]       pbg_q, pbg_d, lbg_q;
    logic [31:0]       off;
    logic              wr_slot, wr_bg;
    logic              hit_d, hit_q, act_q, v1_q;
    logic [11:0]       fg_d, fg_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [11:0]       rgb_q;
    logic              irq_q;
    logic [10:0]       xx, yy, sx, sy;
    logic [7:0]        c;
    logic              unused_ok;

    assign off       = proc_addr - BASE_ADDR;
    assign wr_slot   = proc_we && off[1:0] == 2'd0 && off < 32'(16 * NUM_SLOTS);
    assign wr_bg     = proc_we && off == 32'(16 * NUM_SLOTS);
    assign xx        = {1'b0, x};
    assign yy        = {2'b0, y};
    assign unused_ok = ^proc_data[31:13];

    always_comb begin
        pend_d = pend_q;
        pbg_d  = wr_bg ? proc_data[11:0] : pbg_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_slot && off[7:4] == 4'(i)) begin
                case (off[3:2])
                    2'd0: pend_d[i][7:0]   = proc_data[7:0];
                    2'd1: pend_d[i][17:8]  = proc_data[9:0];
                    2'd2: pend_d[i][26:18] = proc_data[8:0];
                    default: pend_d[i][39:27] = proc_data[12:0];
                endcase
            end
        end
    end

    // Scan high to low so the lowest-index hit overrides the rest.
    always_comb begin
        hit_d  = 1'b0;
        fg_d   = 12'h000;
        addr_d = addr_q;
        sx     = 11'd0;
        sy     = 11'd0;
        c      = 8'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            sx = {1'b0, live_q[i][17:8]};
            sy = {2'b0, live_q[i][26:18]};
            c  = live_q[i][7:0];
            if (live_q[i][39] && c >= 8'd33 && c <= 8'd126 && xx >= sx && xx < sx + 11'(SPRITE_W)
                && yy >= sy && yy < sy + 11'(SPRITE_H)) begin
                hit_d  = 1'b1;
                fg_d   = live_q[i][38:27];
                addr_d = ADDR_W'(c - 8'd33) * ADDR_W'(SPRITE_W * SPRITE_H)
                       + ADDR_W'(SPRITE_W) * ADDR_W'(yy - sy) + ADDR_W'(xx - sx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pend_q[i] <= SLOT_RST;
                live_q[i] <= SLOT_RST;
            end
            pbg_q  <= 12'hFFF;
            lbg_q  <= 12'hFFF;
            irq_q  <= 1'b0;
            v1_q   <= 1'b0;
            hit_q  <= 1'b0;
            act_q  <= 1'b0;
            fg_q   <= 12'h000;
            addr_q <= '0;
            rgb_q  <= 12'h000;
        end else begin
            pend_q <= pend_d;
            pbg_q  <= pbg_d;
            irq_q  <= screen_end;
            if (screen_end) begin
                live_q <= pend_d;
                lbg_q  <= pbg_d;
            end
            if (pix_en) begin
                v1_q   <= 1'b1;
                hit_q  <= hit_d;
                fg_q   <= fg_d;
                act_q  <= active;
                addr_q <= addr_d;
                rgb_q  <= !(v1_q && act_q) ? 12'h000 : (hit_q && sprite_bit) ? fg_q : lbg_q;
            end
        end
    end

    assign sprite_addr = addr_q;
    assign rgb         = rgb_q;
    assign frame_irq   = irq_q;
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// tb_vga_sprite_overlay: directed checks of register commit, compositing, priority, clipping and latency.
module tb_vga_sprite_overlay;
    logic        clk = 1'b0, reset = 1'b1, pix_en = 1'b0, active = 1'b0;
    logic        screen_end = 1'b0, proc_we = 1'b0, sprite_bit = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic [31:0] proc_addr = '0, proc_data = '0;
    logic [17:0] sprite_addr;
    logic [11:0] rgb;
    logic        frame_irq;
    int          checks = 0, errors = 0;
    logic [17:0] a;
    logic [11:0] c;

    always #5 clk = ~clk;

    vga_sprite_overlay dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
        .screen_end(screen_end), .proc_addr(proc_addr), .proc_data(proc_data), .proc_we(proc_we),
        .sprite_addr(sprite_addr), .sprite_bit(sprite_bit), .rgb(rgb), .frame_irq(frame_irq)
    );

    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic act);
        @(negedge clk); x = px; y = py; active = act; pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0;
        @(negedge clk);
    endtask

    // Strobe a pixel, capture its ROM address, then strobe once more to see its colour.
    task automatic probe(input logic [9:0] px, input logic [8:0] py, input logic act, input logic b);
        pix(px, py, act);
        a = sprite_addr;
        sprite_bit = b;
        pix(10'd0, 9'd0, 1'b0);
        c = rgb;
    endtask

    task automatic wr(input logic [31:0] ad, input logic [31:0] d);
        @(negedge clk); proc_addr = ad; proc_data = d; proc_we = 1'b1;
        @(negedge clk); proc_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk); screen_end = 1'b1;
        @(negedge clk); screen_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", frame_irq); end
        checks++; if (sprite_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", sprite_addr); end
        reset = 1'b0;
        probe(10'd10, 9'd10, 1'b1, 1'b0);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL reset_bg got %h exp FFF", c); end
        pix(10'd20, 9'd20, 1'b1);
        pix(10'd21, 9'd20, 1'b1);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL preflight_rgb got %h exp FFF", rgb); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb got %h exp 000", rgb); end
        checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", frame_irq); end
        pix(10'd22, 9'd20, 1'b1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL flush_rgb got %h exp 000", rgb); end
        pix(10'd23, 9'd20, 1'b1);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL first_valid got %h exp FFF", rgb); end
    endtask

    task automatic test_commit();
        wr(32'h2000, 32'h41);
        wr(32'h2004, 32'd100);
        wr(32'h2008, 32'd100);
        wr(32'h200C, 32'h1F00);
        probe(10'd100, 9'd100, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL pending_hidden got %h exp FFF", c); end
        checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", frame_irq); end
        commit();
        checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL irq_pulse got %b exp 1", frame_irq); end
        @(negedge clk);
        checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL irq_end got %b exp 0", frame_irq); end
        probe(10'd100, 9'd100, 1'b1, 1'b1);
        checks++; if (a !== 18'd80000) begin errors++; $display("FAIL commit_addr got %0d exp 80000", a); end
        checks++; if (c !== 12'hF00) begin errors++; $display("FAIL commit_fg got %h exp F00", c); end
        probe(10'd100, 9'd100, 1'b1, 1'b0);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL transparent got %h exp FFF", c); end
        probe(10'd149, 9'd149, 1'b1, 1'b1);
        checks++; if (a !== 18'd82499) begin errors++; $display("FAIL corner_addr got %0d exp 82499", a); end
        checks++; if (c !== 12'hF00) begin errors++; $display("FAIL corner_fg got %h exp F00", c); end
        probe(10'd150, 9'd100, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL right_edge got %h exp FFF", c); end
    endtask

    task automatic test_priority();
        wr(32'h200C, 32'h10F0);
        wr(32'h2010, 32'h42);
        wr(32'h2014, 32'd110);
        wr(32'h2018, 32'd110);
        wr(32'h201C, 32'h100F);
        commit();
        probe(10'd120, 9'd120, 1'b1, 1'b1);
        checks++; if (c !== 12'h0F0) begin errors++; $display("FAIL prio_rgb got %h exp 0F0", c); end
        checks++; if (a !== 18'd81020) begin errors++; $display("FAIL prio_addr got %0d exp 81020", a); end
        probe(10'd120, 9'd120, 1'b1, 1'b0);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL prio_hidden got %h exp FFF", c); end
        wr(32'h200C, 32'h00F0);
        commit();
        probe(10'd120, 9'd120, 1'b1, 1'b1);
        checks++; if (c !== 12'h00F) begin errors++; $display("FAIL slot1_rgb got %h exp 00F", c); end
        checks++; if (a !== 18'd83010) begin errors++; $display("FAIL slot1_addr got %0d exp 83010", a); end
    endtask

    task automatic test_boundary();
        wr(32'h2020, 32'h30);
        wr(32'h2024, 32'd620);
        wr(32'h2028, 32'd460);
        wr(32'h202C, 32'h1ABC);
        commit();
        probe(10'd619, 9'd460, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL left_of_box got %h exp FFF", c); end
        probe(10'd620, 9'd460, 1'b1, 1'b1);
        checks++; if (a !== 18'd37500) begin errors++; $display("FAIL box_origin got %0d exp 37500", a); end
        checks++; if (c !== 12'hABC) begin errors++; $display("FAIL box_origin_rgb got %h exp ABC", c); end
        probe(10'd639, 9'd479, 1'b1, 1'b1);
        checks++; if (a !== 18'd38469) begin errors++; $display("FAIL screen_corner got %0d exp 38469", a); end
        wr(32'h2020, 32'h20);
        commit();
        probe(10'd620, 9'd460, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL char20 got %h exp FFF", c); end
        wr(32'h2020, 32'h7F);
        commit();
        probe(10'd620, 9'd460, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL char7F got %h exp FFF", c); end
        wr(32'h2020, 32'h7E);
        commit();
        probe(10'd669, 9'd460, 1'b1, 1'b1);
        checks++; if (a !== 18'd232549) begin errors++; $display("FAIL char7E_addr got %0d exp 232549", a); end
        probe(10'd670, 9'd460, 1'b1, 1'b1);
        checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL past_width got %h exp FFF", c); end
        checks++; if (a !== 18'd232549) begin errors++; $display("FAIL addr_hold got %0d exp 232549", a); end
    endtask

    task automatic test_same_clk();
        @(negedge clk); proc_addr = 32'h2040; proc_data = 32'h123; proc_we = 1'b1; screen_end = 1'b1;
        @(negedge clk); proc_we = 1'b0; screen_end = 1'b0;
        checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL same_clk_irq got %b exp 1", frame_irq); end
        probe(10'd0, 9'd0, 1'b1, 1'b1);
        checks++; if (c !== 12'h123) begin errors++; $display("FAIL same_clk_bg got %h exp 123", c); end
        wr(32'h2100, 32'hFFFF_FFFF);
        commit();
        probe(10'd0, 9'd0, 1'b1, 1'b1);
        checks++; if (c !== 12'h123) begin errors++; $display("FAIL bad_addr_bg got %h exp 123", c); end
        probe(10'd620, 9'd460, 1'b1, 1'b1);
        checks++; if (c !== 12'hABC) begin errors++; $display("FAIL bad_addr_slot got %h exp ABC", c); end
    endtask

    task automatic test_blanking();
        probe(10'd620, 9'd460, 1'b0, 1'b1);
        checks++; if (c !== 12'h000) begin errors++; $display("FAIL blank_rgb got %h exp 000", c); end
        pix(10'd620, 9'd460, 1'b1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL latency_early got %h exp 000", rgb); end
        sprite_bit = 1'b1;
        pix(10'd0, 9'd0, 1'b0);
        checks++; if (rgb !== 12'hABC) begin errors++; $display("FAIL latency_n1 got %h exp ABC", rgb); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_priority();
        test_boundary();
        test_same_clk();
        test_blanking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
